u_idu_byp_scoreboard: RTL and testbench

//  Parametrised N-issue operand bypass and stall unit for the IDU.
//  It selects each source operand from the youngest valid producer, in this order:
//  BYP_STAGES pipeline stages x ISSUE_NUM slots, then the load return port, then the RF read data.
//  A register scoreboard tracks variable-latency loads and drives per-slot, in-order dispatch stall.
//  A stall FSM counts stall cycles and flags a sticky timeout.
//  It sits between the RF read ports and the dispatcher.

---
 rtl/u_idu_byp_scoreboard.sv | 227 ++++++++++++++++++++++
 tb/tb_u_idu_byp_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_idu_byp_scoreboard.sv
// u_idu_byp_scoreboard
// Issue-group operand bypass and in-order dispatch stall unit for the IDU.
// It selects each source operand from the youngest valid producer. The order is the bypass
// stages (stage 0 youngest, highest slot wins within a stage), then the load return port,
// then RF read data. A busy-bit scoreboard tracks outstanding variable-latency loads and
// produces a prefix grant mask over the issue slots. A small FSM counts consecutive stall
// cycles and raises a sticky timeout flag.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           pipeline flush: clears scoreboard/FSM next cycle, masks grant/stall now
//   src_idx/src_vld per-slot rs1/rs2 index and use flag, packed {slot, rs2, rs1}
//   slot_*          per-slot valid, is-load, rd, rd-valid
//   rf_rdata        RF read data in src_idx order
//   byp_*           non-load results per {stage, slot}
//   ld_ret_*        returning load write-back
//   dispatcher_fire dispatcher accepts the granted slots
//   opnd_data       selected operands in src_idx order
//   slot_grant      in-order dispatch grant mask
//   stall_vld       slot 0 valid but not granted
//   stall_cnt       consecutive stall cycles (saturating)
//   stall_timeout   sticky stall timeout flag
//   ld_outstanding  number of busy registers
module u_idu_byp_scoreboard #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned RF_DEPTH_BIT  = 5,
    parameter int unsigned ISSUE_NUM     = 2,
    parameter int unsigned BYP_STAGES    = 3,
    parameter int unsigned LD_MAX        = 4,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flush,
    input  logic [ISSUE_NUM*2*RF_DEPTH_BIT-1:0]           src_idx,
    input  logic [ISSUE_NUM*2-1:0]                        src_vld,
    input  logic [ISSUE_NUM-1:0]                          slot_vld,
    input  logic [ISSUE_NUM-1:0]                          slot_is_load,
    input  logic [ISSUE_NUM*RF_DEPTH_BIT-1:0]             slot_rd,
    input  logic [ISSUE_NUM-1:0]                          slot_rd_vld,
    input  logic [ISSUE_NUM*2*DATA_WIDTH-1:0]             rf_rdata,
    input  logic [BYP_STAGES*ISSUE_NUM-1:0]               byp_vld,
    input  logic [BYP_STAGES*ISSUE_NUM*RF_DEPTH_BIT-1:0]  byp_rd,
    input  logic [BYP_STAGES*ISSUE_NUM*DATA_WIDTH-1:0]    byp_data,
    input  logic                                          ld_ret_vld,
    input  logic [RF_DEPTH_BIT-1:0]                       ld_ret_rd,
    input  logic [DATA_WIDTH-1:0]                         ld_ret_data,
    input  logic                                          dispatcher_fire,
    output logic [ISSUE_NUM*2*DATA_WIDTH-1:0]             opnd_data,
    output logic [ISSUE_NUM-1:0]                          slot_grant,
    output logic                                          stall_vld,
    output logic [$clog2(STALL_TIMEOUT+1)-1:0]            stall_cnt,
    output logic                                          stall_timeout,
    output logic [$clog2(LD_MAX+1)-1:0]                   ld_outstanding
);

    localparam int unsigned NumRegs = 1 << RF_DEPTH_BIT;
    localparam int unsigned NumSrc  = ISSUE_NUM * 2;
    localparam int unsigned NumByp  = BYP_STAGES * ISSUE_NUM;
    localparam int unsigned CntW    = $clog2(STALL_TIMEOUT + 1);
    localparam int unsigned LdW     = $clog2(LD_MAX + 1);

    typedef enum logic [1:0] {StIdle, StStall, StTout} state_e;

    state_e              state_q, state_d;
    logic [NumRegs-1:0]  busy_q, busy_d;
    logic [CntW-1:0]     stall_cnt_q, stall_cnt_d;
    logic                timeout_q, timeout_d;

    logic [RF_DEPTH_BIT-1:0] src_reg [NumSrc];
    logic [NumSrc-1:0]       src_used;
    logic [NumSrc-1:0]       src_haz;
    logic [ISSUE_NUM-1:0]    blocked;
    logic [ISSUE_NUM-1:0]    grant;
    int unsigned             busy_cnt;
    int unsigned             ld_cnt;
    logic                    prev_grant;

    // Operand select and per-source hazard
    for (genvar s = 0; s < NumSrc; s++) begin : g_src
        logic                  ld_hit;
        logic                  byp_hit;
        logic [DATA_WIDTH-1:0] sel;

        assign src_reg[s]  = src_idx[s*RF_DEPTH_BIT +: RF_DEPTH_BIT];
        assign src_used[s] = src_vld[s] && (src_reg[s] != '0);
        assign ld_hit      = ld_ret_vld && (ld_ret_rd == src_reg[s]);

        always_comb begin
            sel     = ld_hit ? ld_ret_data : rf_rdata[s*DATA_WIDTH +: DATA_WIDTH];
            byp_hit = 1'b0;
            // Walk from oldest to youngest producer so the youngest match is written last.
            for (int b = NumByp - 1; b >= 0; b--) begin
                // Reverse slot order inside a stage so the highest slot is visited last.
                int e;
                e = (b / ISSUE_NUM) * ISSUE_NUM + (ISSUE_NUM - 1 - (b % ISSUE_NUM));
                if (byp_vld[e] && (byp_rd[e*RF_DEPTH_BIT +: RF_DEPTH_BIT] == src_reg[s])) begin
                    sel     = byp_data[e*DATA_WIDTH +: DATA_WIDTH];
                    byp_hit = 1'b1;
                end
            end
        end

        assign opnd_data[s*DATA_WIDTH +: DATA_WIDTH] = src_used[s] ? sel : '0;
        // A bypass or load-return match carries the newest value, so busy does not apply.
        assign src_haz[s] = src_used[s] && busy_q[src_reg[s]] && !ld_hit && !byp_hit;
    end

    // Per-slot blocking conditions other than the load-capacity limit
    always_comb begin
        blocked = '0;
        for (int j = 0; j < ISSUE_NUM; j++) begin
            blocked[j] = src_haz[2*j] || src_haz[2*j+1];
            for (int i = 0; i < j; i++) begin
                for (int r = 0; r < 2; r++) begin
                    if (slot_rd_vld[i] && src_used[2*j+r] &&
                        (src_reg[2*j+r] == slot_rd[i*RF_DEPTH_BIT +: RF_DEPTH_BIT])) begin
                        blocked[j] = 1'b1;
                    end
                end
            end
            if (slot_is_load[j] && busy_q[slot_rd[j*RF_DEPTH_BIT +: RF_DEPTH_BIT]]) begin
                blocked[j] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_cnt = 0;
        for (int r = 0; r < NumRegs; r++) begin
            busy_cnt += int'(busy_q[r]);
        end
    end

    // In-order prefix grant; loads granted earlier in the group consume capacity.
    always_comb begin
        grant      = '0;
        ld_cnt     = busy_cnt;
        prev_grant = 1'b1;
        for (int j = 0; j < ISSUE_NUM; j++) begin
            grant[j] = prev_grant && slot_vld[j] && !blocked[j] && !flush &&
                       !(slot_is_load[j] && (ld_cnt >= LD_MAX));
            if (grant[j] && slot_is_load[j]) begin
                ld_cnt = ld_cnt + 1;
            end
            prev_grant = grant[j];
        end
    end

    assign slot_grant     = grant;
    assign stall_vld      = slot_vld[0] && !grant[0] && !flush;
    assign ld_outstanding = LdW'(busy_cnt);
    assign stall_cnt      = stall_cnt_q;
    assign stall_timeout  = timeout_q;

    // Scoreboard: the set is applied after the clear so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (ld_ret_vld) begin
            busy_d[ld_ret_rd] = 1'b0;
        end
        if (dispatcher_fire) begin
            for (int j = 0; j < ISSUE_NUM; j++) begin
                if (grant[j] && slot_is_load[j]) begin
                    busy_d[slot_rd[j*RF_DEPTH_BIT +: RF_DEPTH_BIT]] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
        if (flush) begin
            busy_d = '0;
        end
    end

    // Stall FSM
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;
        case (state_q)
            StIdle: begin
                if (stall_vld) begin
                    state_d     = StStall;
                    stall_cnt_d = CntW'(1);
                end
            end
            StStall, StTout: begin
                if (!stall_vld) begin
                    state_d     = StIdle;
                    stall_cnt_d = '0;
                end else begin
                    if (stall_cnt_q != CntW'(STALL_TIMEOUT)) begin
                        stall_cnt_d = stall_cnt_q + CntW'(1);
                    end
                    if ((state_q == StStall) && (stall_cnt_q == CntW'(STALL_TIMEOUT - 1))) begin
                        state_d   = StTout;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                stall_cnt_d = '0;
            end
        endcase
        if (flush) begin
            state_d     = StIdle;
            stall_cnt_d = '0;
            timeout_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_u_idu_byp_scoreboard.sv
// Self-checking bench for u_idu_byp_scoreboard (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_u_idu_byp_scoreboard;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [19:0]  src_idx;
    logic [3:0]   src_vld;
    logic [1:0]   slot_vld;
    logic [1:0]   slot_is_load;
    logic [9:0]   slot_rd;
    logic [1:0]   slot_rd_vld;
    logic [127:0] rf_rdata;
    logic [5:0]   byp_vld;
    logic [29:0]  byp_rd;
    logic [191:0] byp_data;
    logic         ld_ret_vld;
    logic [4:0]   ld_ret_rd;
    logic [31:0]  ld_ret_data;
    logic         dispatcher_fire;
    logic [127:0] opnd_data;
    logic [1:0]   slot_grant;
    logic         stall_vld;
    logic [6:0]   stall_cnt;
    logic         stall_timeout;
    logic [2:0]   ld_outstanding;

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] exp_q[$];

    u_idu_byp_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .src_idx        (src_idx),
        .src_vld        (src_vld),
        .slot_vld       (slot_vld),
        .slot_is_load   (slot_is_load),
        .slot_rd        (slot_rd),
        .slot_rd_vld    (slot_rd_vld),
        .rf_rdata       (rf_rdata),
        .byp_vld        (byp_vld),
        .byp_rd         (byp_rd),
        .byp_data       (byp_data),
        .ld_ret_vld     (ld_ret_vld),
        .ld_ret_rd      (ld_ret_rd),
        .ld_ret_data    (ld_ret_data),
        .dispatcher_fire(dispatcher_fire),
        .opnd_data      (opnd_data),
        .slot_grant     (slot_grant),
        .stall_vld      (stall_vld),
        .stall_cnt      (stall_cnt),
        .stall_timeout  (stall_timeout),
        .ld_outstanding (ld_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 1'b0; src_idx = '0; src_vld = '0; slot_vld = '0; slot_is_load = '0;
        slot_rd = '0; slot_rd_vld = '0; byp_vld = '0; byp_rd = '0; byp_data = '0;
        ld_ret_vld = 1'b0; ld_ret_rd = '0; ld_ret_data = '0; dispatcher_fire = 1'b0;
        for (int k = 0; k < 4; k++) rf_rdata[k*32 +: 32] = 32'hF000_0000 + k;
    endtask

    task automatic set_src(input int s, input int r, input int idx);
        src_idx[(s*2+r)*5 +: 5] = idx[4:0];
        src_vld[s*2+r] = 1'b1;
    endtask

    task automatic set_instr(input int s, input logic ld, input int rd);
        slot_vld[s] = 1'b1; slot_is_load[s] = ld; slot_rd[s*5 +: 5] = rd[4:0];
        slot_rd_vld[s] = 1'b1;
    endtask

    task automatic set_byp(input int st, input int k, input int rd, input logic [31:0] d);
        byp_vld[st*2+k] = 1'b1; byp_rd[(st*2+k)*5 +: 5] = rd[4:0];
        byp_data[(st*2+k)*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_inputs();
        step(); step();
        rst = 1'b0; #1;
        n_chk++; if (stall_cnt !== 7'd0) $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); else n_pass++;
        n_chk++; if (stall_timeout !== 1'b0) $display("FAIL reset_tout: got %b expected 0", stall_timeout); else n_pass++;
        n_chk++; if (ld_outstanding !== 3'd0) $display("FAIL reset_ldout: got %0d expected 0", ld_outstanding); else n_pass++;
        n_chk++; if (slot_grant !== 2'b00 || stall_vld !== 1'b0)
            $display("FAIL reset_grant: got %b/%b expected 00/0", slot_grant, stall_vld); else n_pass++;
    endtask

    task automatic test_intra_group();
        clear_inputs();
        set_instr(0, 1'b0, 5); set_src(0, 0, 1); set_src(0, 1, 2);
        set_instr(1, 1'b0, 6); set_src(1, 0, 5);
        #1;
        n_chk++; if (slot_grant !== 2'b01) $display("FAIL intra_dep: got %b expected 01", slot_grant); else n_pass++;
        n_chk++; if (stall_vld !== 1'b0) $display("FAIL intra_stall: got %b expected 0", stall_vld); else n_pass++;
        src_idx[10 +: 5] = 5'd7; #1;
        n_chk++; if (slot_grant !== 2'b11) $display("FAIL intra_nodep: got %b expected 11", slot_grant); else n_pass++;
        // A younger slot's rd read by an older slot is not a hazard
        set_src(0, 0, 6); #1;
        n_chk++; if (slot_grant !== 2'b11) $display("FAIL intra_rev: got %b expected 11", slot_grant); else n_pass++;
    endtask

    task automatic test_bypass_priority();
        logic [31:0] e;
        logic [31:0] got;
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            set_instr(0, 1'b0, 20); set_src(0, 0, 7);
            e = 32'hF000_0000;
            case (i)
                1: begin ld_ret_vld = 1; ld_ret_rd = 7; ld_ret_data = 32'h5A5A; e = 32'h5A5A; end
                2: begin ld_ret_vld = 1; ld_ret_rd = 7; ld_ret_data = 32'h5A5A;
                         set_byp(2, 0, 7, 32'h2222); e = 32'h2222; end
                3: begin ld_ret_vld = 1; ld_ret_rd = 7; ld_ret_data = 32'h5A5A;
                         set_byp(2, 0, 7, 32'h2222); set_byp(1, 0, 7, 32'h5555); e = 32'h5555; end
                4: begin set_byp(1, 0, 7, 32'h5555); set_byp(0, 1, 7, 32'hAAAA); e = 32'hAAAA; end
                5: begin set_byp(0, 0, 7, 32'h1111); set_byp(0, 1, 7, 32'hAAAA); e = 32'hAAAA; end
                6: begin set_byp(0, 1, 7, 32'hAAAA); src_vld[0] = 1'b0; e = 32'h0; end
                7: begin src_idx[4:0] = 5'd0; set_byp(0, 0, 0, 32'hDEAD); e = 32'h0; end
                8: begin set_byp(0, 0, 8, 32'h9999); e = 32'hF000_0000; end
                default: ;
            endcase
            exp_q.push_back(e);
            #1;
            got = opnd_data[31:0];
            e = exp_q.pop_front();
            n_chk++; if (got !== e) $display("FAIL byp_prio_%0d: got %h expected %h", i, got, e); else n_pass++;
        end
        clear_inputs();
        set_instr(1, 1'b0, 20); set_src(1, 1, 3);
        exp_q.push_back(32'hF000_0003);
        #1;
        e = exp_q.pop_front();
        n_chk++; if (opnd_data[127:96] !== e) $display("FAIL rf_map: got %h expected %h", opnd_data[127:96], e); else n_pass++;
    endtask

    task automatic test_load_stall();
        logic [31:0] e;
        clear_inputs();
        set_instr(0, 1'b1, 9); dispatcher_fire = 1'b1; #1;
        n_chk++; if (slot_grant !== 2'b01) $display("FAIL ld_issue: got %b expected 01", slot_grant); else n_pass++;
        step();
        clear_inputs(); dispatcher_fire = 1'b1;
        set_instr(0, 1'b0, 10); set_src(0, 0, 9);
        set_instr(1, 1'b0, 11); set_src(1, 0, 2);
        #1;
        n_chk++; if (ld_outstanding !== 3'd1) $display("FAIL ld_busy: got %0d expected 1", ld_outstanding); else n_pass++;
        for (int c = 1; c <= 3; c++) begin
            n_chk++; if (slot_grant !== 2'b00 || stall_vld !== 1'b1)
                $display("FAIL ld_stall_%0d: got %b/%b expected 00/1", c, slot_grant, stall_vld); else n_pass++;
            step();
            n_chk++; if (stall_cnt !== 7'(c)) $display("FAIL ld_cnt_%0d: got %0d expected %0d", c, stall_cnt, c); else n_pass++;
        end
        ld_ret_vld = 1'b1; ld_ret_rd = 5'd9; ld_ret_data = 32'h1234;
        exp_q.push_back(32'h1234);
        #1;
        e = exp_q.pop_front();
        n_chk++; if (opnd_data[31:0] !== e) $display("FAIL ld_ret_opnd: got %h expected %h", opnd_data[31:0], e); else n_pass++;
        n_chk++; if (slot_grant !== 2'b11) $display("FAIL ld_ret_grant: got %b expected 11", slot_grant); else n_pass++;
        step();
        n_chk++; if (ld_outstanding !== 3'd0 || stall_cnt !== 7'd0)
            $display("FAIL ld_ret_after: got %0d/%0d expected 0/0", ld_outstanding, stall_cnt); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_waw_bypass();
        clear_inputs();
        set_instr(0, 1'b1, 9); dispatcher_fire = 1'b1; step();
        clear_inputs();
        set_instr(0, 1'b1, 9); #1;
        n_chk++; if (slot_grant !== 2'b00) $display("FAIL waw: got %b expected 00", slot_grant); else n_pass++;
        clear_inputs();
        set_instr(0, 1'b0, 10); set_src(0, 1, 9); set_byp(2, 1, 9, 32'hBEEF); #1;
        n_chk++; if (slot_grant !== 2'b01 || opnd_data[63:32] !== 32'hBEEF)
            $display("FAIL byp_over_busy: got %b/%h expected 01/beef", slot_grant, opnd_data[63:32]); else n_pass++;
        clear_inputs();
        ld_ret_vld = 1'b1; ld_ret_rd = 5'd9; step();
        // Load to x9 and a return to x9 in the same cycle: the new load stays busy
        set_instr(0, 1'b1, 9); dispatcher_fire = 1'b1; #1;
        n_chk++; if (slot_grant !== 2'b01) $display("FAIL setclr_grant: got %b expected 01", slot_grant); else n_pass++;
        step();
        n_chk++; if (ld_outstanding !== 3'd1) $display("FAIL setclr_wins: got %0d expected 1", ld_outstanding); else n_pass++;
        clear_inputs();
        ld_ret_vld = 1'b1; ld_ret_rd = 5'd9; step();
        clear_inputs();
        n_chk++; if (ld_outstanding !== 3'd0) $display("FAIL setclr_drain: got %0d expected 0", ld_outstanding); else n_pass++;
    endtask

    task automatic test_ld_max();
        clear_inputs(); dispatcher_fire = 1'b1;
        set_instr(0, 1'b1, 1); set_instr(1, 1'b1, 2); #1;
        n_chk++; if (slot_grant !== 2'b11) $display("FAIL ldmax_g1: got %b expected 11", slot_grant); else n_pass++;
        step();
        clear_inputs(); dispatcher_fire = 1'b1;
        set_instr(0, 1'b1, 3); step();
        clear_inputs(); dispatcher_fire = 1'b1;
        set_instr(0, 1'b1, 4); set_instr(1, 1'b1, 5); #1;
        n_chk++; if (slot_grant !== 2'b01) $display("FAIL ldmax_group: got %b expected 01", slot_grant); else n_pass++;
        step();
        clear_inputs(); dispatcher_fire = 1'b1;
        set_instr(0, 1'b1, 10); #1;
        n_chk++; if (slot_grant !== 2'b00 || stall_vld !== 1'b1)
            $display("FAIL ldmax_fifth: got %b/%b expected 00/1", slot_grant, stall_vld); else n_pass++;
        n_chk++; if (ld_outstanding !== 3'd4) $display("FAIL ldmax_out: got %0d expected 4", ld_outstanding); else n_pass++;
        flush = 1'b1; #1;
        n_chk++; if (slot_grant !== 2'b00 || stall_vld !== 1'b0)
            $display("FAIL flush_mask: got %b/%b expected 00/0", slot_grant, stall_vld); else n_pass++;
        step();
        clear_inputs(); #1;
        n_chk++; if (ld_outstanding !== 3'd0) $display("FAIL flush_busy: got %0d expected 0", ld_outstanding); else n_pass++;
    endtask

    task automatic test_timeout();
        clear_inputs();
        set_instr(0, 1'b1, 9); dispatcher_fire = 1'b1; step();
        clear_inputs();
        set_instr(0, 1'b0, 10); set_src(0, 0, 9);
        for (int c = 1; c <= 64; c++) begin
            step();
            if (c == 63) begin
                n_chk++; if (stall_cnt !== 7'd63 || stall_timeout !== 1'b0)
                    $display("FAIL tout_63: got %0d/%b expected 63/0", stall_cnt, stall_timeout); else n_pass++;
            end
        end
        n_chk++; if (stall_cnt !== 7'd64 || stall_timeout !== 1'b1)
            $display("FAIL tout_64: got %0d/%b expected 64/1", stall_cnt, stall_timeout); else n_pass++;
        step(); step(); step();
        n_chk++; if (stall_cnt !== 7'd64) $display("FAIL tout_sat: got %0d expected 64", stall_cnt); else n_pass++;
        slot_vld = 2'b00; step();
        n_chk++; if (stall_cnt !== 7'd0 || stall_timeout !== 1'b1)
            $display("FAIL tout_sticky: got %0d/%b expected 0/1", stall_cnt, stall_timeout); else n_pass++;
        flush = 1'b1; step();
        flush = 1'b0;
        n_chk++; if (stall_timeout !== 1'b0 || ld_outstanding !== 3'd0)
            $display("FAIL tout_flush: got %b/%0d expected 0/0", stall_timeout, ld_outstanding); else n_pass++;
        slot_vld = 2'b01; #1;
        n_chk++; if (slot_grant !== 2'b01) $display("FAIL tout_regrant: got %b expected 01", slot_grant); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs(); dispatcher_fire = 1'b1;
        set_instr(0, 1'b1, 1); set_instr(1, 1'b1, 2); step();
        clear_inputs();
        set_instr(0, 1'b0, 10); set_src(0, 0, 1);
        step(); step();
        n_chk++; if (stall_cnt !== 7'd2 || ld_outstanding !== 3'd2)
            $display("FAIL rstmid_pre: got %0d/%0d expected 2/2", stall_cnt, ld_outstanding); else n_pass++;
        rst = 1'b1; step();
        rst = 1'b0;
        n_chk++; if (stall_cnt !== 7'd0 || ld_outstanding !== 3'd0)
            $display("FAIL rstmid_post: got %0d/%0d expected 0/0", stall_cnt, ld_outstanding); else n_pass++;
        clear_inputs();
        ld_ret_vld = 1'b1; ld_ret_rd = 5'd1; ld_ret_data = 32'h77; step();
        clear_inputs();
        n_chk++; if (ld_outstanding !== 3'd0 || stall_cnt !== 7'd0)
            $display("FAIL rstmid_ret: got %0d/%0d expected 0/0", ld_outstanding, stall_cnt); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_intra_group();
        test_bypass_priority();
        test_load_stall();
        test_waw_bypass();
        test_ld_max();
        test_timeout();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
